tt_um_michaelbell_spi_slave: RTL and testbench

TT_UM_MICHAELBELL_SPI_SLAVE -- requirements
Module: tt_um_michaelbell_spi_slave

---
 rtl/tt_spi_pkg.sv | 24 ++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/tt_um_michaelbell_spi_slave.sv | 196 +++++++++++++++++++
 tb/tb_tt_um_michaelbell_spi_slave.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_spi_pkg.sv
// Shared constants and types for the SPI-slave memory block.
//   CMD_*     : recognised command opcodes
//   MEM_DEPTH : number of bytes in the register file
//   state_t   : transaction FSM states
package tt_spi_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_QREAD = 8'h6B;

  localparam int MEM_DEPTH = 8;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_READ   = 3'd4,
    ST_QREAD  = 3'd5,
    ST_IGNORE = 3'd6
  } state_t;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex digit to 7-segment decoder.
//   hex_i [3:0] : digit 0..F
//   seg_o [6:0] : segments gfedcba, active-high (bit0 = a)
module hex_to_7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h00;
    case (hex_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/tt_um_michaelbell_spi_slave.sv
// SPI mode-0 slave fronting an 8-byte register file, with single-bit and
// quad read, a 7-segment view of mem[0][3:0] and a nibble debug port.
//   clk, rst_n : system clock (oversamples SPI), async active-low reset
//   ena        : unused
//   ui_in      : [0] SCK, [1] CS_n, [5:2] debug_addr
//   uo_out     : [6:0] segments a..g, [7] dot (transaction active)
//   uio_in     : [0] MOSI
//   uio_out    : [1] MISO, [3:0] quad data, [7:4] debug_data
//   uio_oe     : 0xF2, or 0xFF during the quad-read data phase
//
// Handshake: there is no valid/ready pair; SPI framing is CS_n low for the
// whole transaction, MOSI sampled on synchronized SCK rise, outputs updated
// on synchronized SCK fall.
module tt_um_michaelbell_spi_slave
  import tt_spi_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic unused_inputs;
  assign unused_inputs = ^{ena, ui_in[7:6], uio_in[7:1]};

  // Pin synchronizers and edge detection
  logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
  logic       sck_prev_q;
  logic       sck_s, cs_n_s, mosi_s, sck_rise, sck_fall;

  // Armed once a genuine CS_n high has been seen after reset, so a CS_n held
  // low across reset cannot start a transaction part-way through.
  logic [1:0] flush_q;
  logic       armed_q;

  state_t              state_q, state_d, target_q, target_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                miso_q, miso_d;
  logic [3:0]          quad_q, quad_d;
  logic                qact_q, qact_d;
  logic [7:0]          mem_q [MEM_DEPTH];
  logic                mem_we;
  logic [7:0]          byte_in, cur_byte, dbg_byte;
  logic [3:0]          dbg_nib, data_nib;
  logic [6:0]          seg;

  assign sck_s    = sck_sync_q[1];
  assign cs_n_s   = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign byte_in  = {shift_q[6:0], mosi_s};
  assign cur_byte = mem_q[addr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sck_prev_q  <= 1'b0;
      flush_q     <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[0], ui_in[0]};
      cs_sync_q   <= {cs_sync_q[0], ui_in[1]};
      mosi_sync_q <= {mosi_sync_q[0], uio_in[0]};
      sck_prev_q  <= sck_s;
      flush_q     <= {flush_q[0], 1'b1};
      armed_q     <= armed_q | (flush_q[1] & cs_n_s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      target_q  <= ST_IGNORE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      quad_q    <= '0;
      qact_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
      quad_q    <= quad_d;
      qact_q    <= qact_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    miso_d    = miso_q;
    quad_d    = quad_q;
    qact_d    = qact_q;
    mem_we    = 1'b0;
    if (cs_n_s) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
      quad_d    = '0;
      qact_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (armed_q) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
          end
        end
        ST_CMD, ST_ADDR, ST_WRITE: begin
          if (sck_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_CMD) begin
                state_d = ST_ADDR;
                case (byte_in)
                  CMD_WRITE: target_d = ST_WRITE;
                  CMD_READ:  target_d = ST_READ;
                  CMD_QREAD: target_d = ST_QREAD;
                  default:   state_d  = ST_IGNORE;
                endcase
              end else if (state_q == ST_ADDR) begin
                addr_d  = byte_in[ADDR_W-1:0];
                state_d = target_q;
              end else begin
                mem_we = 1'b1;
                addr_d = addr_q + 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          if (sck_fall) begin
            miso_d    = cur_byte[3'd7 - bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) addr_d = addr_q + 1'b1;
          end
        end
        ST_QREAD: begin
          if (sck_fall) begin
            qact_d    = 1'b1;
            quad_d    = bit_cnt_q[0] ? cur_byte[3:0] : cur_byte[7:4];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q[0]) addr_d = addr_q + 1'b1;
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= byte_in;
    end
  end

  // Debug nibble: debug_addr[3:1] selects the byte, [0] selects high nibble.
  assign dbg_byte = mem_q[ui_in[5:3]];
  assign dbg_nib  = ui_in[2] ? dbg_byte[7:4] : dbg_byte[3:0];

  always_comb begin
    data_nib = 4'h0;
    if (state_q == ST_QREAD && qact_q) data_nib = quad_q;
    else if (state_q == ST_READ)       data_nib = {2'b00, miso_q, 1'b0};
  end

  hex_to_7seg u_seg (
    .hex_i (mem_q[0][3:0]),
    .seg_o (seg)
  );

  assign uo_out  = {~cs_n_s, seg};
  assign uio_out = {dbg_nib, data_nib};
  assign uio_oe  = (state_q == ST_QREAD && qact_q) ? 8'hFF : 8'hF2;

endmodule

// File: tb/tb_tt_um_michaelbell_spi_slave.sv
module tb_tt_um_michaelbell_spi_slave;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;
  logic [3:0] dbg = 4'h0;
  logic [7:0] ui_in, uio_in, uo_out, uio_out, uio_oe;

  assign ui_in  = {2'b00, dbg, cs_n, sck};
  assign uio_in = {7'b0000000, mosi};

  tt_um_michaelbell_spi_slave dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (1'b1),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return tab[h];
  endfunction

  // Driver tasks: SCK half period is 4 system clocks (8x oversampling).
  task automatic spi_clk(input logic b, output logic [3:0] q, output logic [7:0] oe);
    mosi = b;
    repeat (4) @(negedge clk);
    q  = uio_out[3:0];
    oe = uio_oe;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx);
    logic [3:0] q;
    logic [7:0] oe;
    for (int i = 7; i >= 0; i--) spi_clk(tx[i], q, oe);
  endtask

  task automatic read_byte(output logic [7:0] rx);
    logic [3:0] q;
    logic [7:0] oe;
    for (int i = 7; i >= 0; i--) begin
      spi_clk(1'b0, q, oe);
      rx[i] = q[1];
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic write_txn(input logic [2:0] addr, input logic [7:0] d0);
    cs_low();
    spi_byte(8'h02);
    spi_byte({5'b0, addr});
    spi_byte(d0);
    cs_high();
    model[addr] = d0;
  endtask

  task automatic check_dbg_all(input string tag);
    for (int a = 0; a < 16; a++) begin
      dbg = a[3:0];
      @(negedge clk);
      check(tag, uio_out[7:4], a[0] ? model[a/2][7:4] : model[a/2][3:0]);
    end
    dbg = 4'h0;
  endtask

  logic [7:0] rx, oe, rnd;
  logic [3:0] q;

  initial begin
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uo", uo_out, 8'h3F);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'hF2);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_dbg_all("rst_dbg");

    // Write 02 00 A5 3C
    cs_low();
    check("dot_active", uo_out[7], 1'b1);
    spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'hA5); spi_byte(8'h3C);
    cs_high();
    model[0] = 8'hA5; model[1] = 8'h3C;
    check("dot_idle", uo_out[7], 1'b0);
    check("seg_a5", uo_out[6:0], 7'h6D);
    dbg = 4'd0; @(negedge clk); check("dbg0", uio_out[7:4], 4'h5);
    dbg = 4'd1; @(negedge clk); check("dbg1", uio_out[7:4], 4'hA);
    dbg = 4'd2; @(negedge clk); check("dbg2", uio_out[7:4], 4'hC);
    dbg = 4'd3; @(negedge clk); check("dbg3", uio_out[7:4], 4'h3);

    // Single read 03 00 + 16 clocks
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    cs_low();
    spi_byte(8'h03); spi_byte(8'h00);
    for (int k = 0; k < 2; k++) begin
      read_byte(rx);
      check("oe_read", uio_oe, 8'hF2);
      if (exp_q.size() > 0) check("read_byte", rx, exp_q.pop_front());
    end
    cs_high();
    check("read_idle_data", uio_out[3:0], 4'h0);

    // Quad read wrapping from mem[7] to mem[0]
    write_txn(3'd7, 8'h5E);
    exp_q.push_back(8'h05); exp_q.push_back(8'h0E);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h05);
    cs_low();
    spi_byte(8'h6B); spi_byte(8'h07);
    check("oe_pre_quad", uio_oe, 8'hF2);
    for (int k = 0; k < 4; k++) begin
      spi_clk(1'b0, q, oe);
      check("oe_quad", oe, 8'hFF);
      if (exp_q.size() > 0) check("quad_nib", {4'h0, q}, exp_q.pop_front());
    end
    cs_high();
    check("oe_after_quad", uio_oe, 8'hF2);
    check("quad_idle_data", uio_out[3:0], 4'h0);

    // Partial byte discarded
    cs_low();
    spi_byte(8'h02); spi_byte(8'h03);
    for (int i = 0; i < 5; i++) spi_clk(1'b1, q, oe);
    cs_high();
    check_dbg_all("partial_dbg");

    // Unknown opcode: no change, MISO low
    cs_low();
    spi_byte(8'hFF);
    for (int i = 0; i < 24; i++) begin
      spi_clk(1'b1, q, oe);
      check("ignore_miso", uio_out[1], 1'b0);
    end
    cs_high();
    check_dbg_all("ignore_dbg");
    check("ignore_seg", uo_out[6:0], seg_of(model[0][3:0]));

    // Reset mid write; bytes clocked with CS_n still low must be ignored
    cs_low();
    spi_byte(8'h02); spi_byte(8'h01);
    for (int i = 0; i < 4; i++) spi_clk(1'b1, q, oe);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    spi_byte(8'h02); spi_byte(8'h05); spi_byte(8'h33);
    cs_high();
    check("rst_mid_seg", uo_out[6:0], 7'h3F);
    check_dbg_all("rst_mid_dbg");
    write_txn(3'd2, 8'h77);
    check_dbg_all("post_rst_write");

    // Random byte written and read back through MISO
    rnd = 8'($urandom_range(0, 255));
    write_txn(3'd4, rnd);
    exp_q.push_back(rnd);
    cs_low();
    spi_byte(8'h03); spi_byte(8'h04);
    read_byte(rx);
    if (exp_q.size() > 0) check("rand_read", rx, exp_q.pop_front());
    cs_high();
    check_dbg_all("rand_dbg");
    check("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
